// File: rtl/comparator_search_ctrl.sv
// comparator_search_ctrl
//   Successive-approximation search initiator. It drives a trial value onto
//   Guess, and an external combinational comparator compares that value with
//   a hidden value A. The block reads back the comparator's Greater/Less/Equal
//   flags and refines Guess one bit per cycle, from the MSB down to the LSB,
//   until it finds A.
//
// Ports
//   clk      : single clock, rising-edge active
//   rst      : asynchronous, active-high reset
//   Start    : begin a search (accepted in IDLE only)
//   Greater  : comparator flag, A > Guess
//   Less     : comparator flag, A < Guess
//   Equal    : comparator flag, A == Guess
//   Guess    : registered trial value (comparator operand B)
//   Result   : registered search result
//   Found    : Result confirmed equal to A
//   Error    : comparator flags were not exactly one-hot
//   Busy     : search in progress (TRIAL/VERIFY)
//   Done     : one-cycle completion pulse

module comparator_search_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             Greater,
    input  logic             Less,
    input  logic             Equal,
    output logic [WIDTH-1:0] Guess,
    output logic [WIDTH-1:0] Result,
    output logic             Found,
    output logic             Error,
    output logic             Busy,
    output logic             Done
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        TRIAL,
        VERIFY,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] guess_q;
    logic [WIDTH-1:0] result_q;
    logic [IW-1:0]    idx_q;
    logic             found_q;
    logic             error_q;
    logic             busy_q;
    logic             done_q;

    logic             flagsOneHot;
    logic [WIDTH-1:0] decidedGuess;
    logic [WIDTH-1:0] nextBitMask;

    // The comparator answer is only trustworthy when exactly one flag is set.
    assign flagsOneHot = (Greater & ~Less & ~Equal) |
                         (~Greater & Less & ~Equal) |
                         (~Greater & ~Less & Equal);

    // "Less" means the trial bit overshot A and must be dropped. "Greater"
    // keeps the bit. Only single bits are set or cleared, so there are no carries.
    assign decidedGuess = Less ? (guess_q & ~(WIDTH'(1) << idx_q)) : guess_q;
    assign nextBitMask  = WIDTH'(1) << (idx_q - IW'(1));

    // Single FSM with every output registered. Result/Found/Error/Guess keep
    // their values after DONE until the next accepted Start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            guess_q  <= '0;
            result_q <= '0;
            idx_q    <= '0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        guess_q <= WIDTH'(1) << (WIDTH - 1);
                        idx_q   <= IW'(WIDTH - 1);
                        found_q <= 1'b0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= TRIAL;
                    end
                end

                TRIAL: begin
                    if (!flagsOneHot) begin
                        result_q <= guess_q;
                        found_q  <= 1'b0;
                        error_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else if (Equal) begin
                        result_q <= guess_q;
                        found_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else if (idx_q != '0) begin
                        guess_q <= decidedGuess | nextBitMask;
                        idx_q   <= idx_q - IW'(1);
                    end else begin
                        // All bits are decided. One more compare confirms the value.
                        guess_q <= decidedGuess;
                        state_q <= VERIFY;
                    end
                end

                VERIFY: begin
                    result_q <= guess_q;
                    found_q  <= flagsOneHot & Equal;
                    error_q  <= ~flagsOneHot;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end

                DONE: begin
                    // A Start in this cycle is deliberately not looked at.
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Guess  = guess_q;
    assign Result = result_q;
    assign Found  = found_q;
    assign Error  = error_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: doc/comparator_search_ctrl.md
COMPARATOR_SEARCH_CTRL -- requirements
Module: comparator_search_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 3, operand width in bits (WIDTH >= 2).
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk      input   1      single clock; all state changes on its rising edge
- rst      input   1      reset, asynchronous, active-high
- Start    input   1      begin search; sampled in IDLE only
- Greater  input   1      external comparator flag: hidden value A > Guess
- Less     input   1      external comparator flag: A < Guess
- Equal    input   1      external comparator flag: A == Guess
- Guess    output  WIDTH  registered trial value, drives comparator operand B
- Result   output  WIDTH  search result, registered
- Found    output  1      Result confirmed equal to A
- Error    output  1      comparator flags were not exactly one-hot
- Busy     output  1      search in progress
- Done     output  1      one-cycle completion pulse

Function
REQ-003 The block SHALL be a successive-approximation initiator: it drives Guess and samples the three flags returned by an external combinational comparator.
REQ-004 The FSM SHALL have states IDLE, TRIAL, VERIFY and DONE.
REQ-005 In IDLE with Start=1, the block SHALL load Guess = 1<<(WIDTH-1), load bit index = WIDTH-1 and go to TRIAL; Start=0 holds IDLE.
REQ-006 In TRIAL the block SHALL sample the flags at the end of the cycle. The flags reflect the Guess registered that cycle.
REQ-007 TRIAL, Equal only: Result <= Guess, Found <= 1, next state DONE.
REQ-008 TRIAL, Greater only: keep the current bit. Less only: clear the current bit.
REQ-009 TRIAL, index > 0: set bit index-1 in Guess, decrement index, stay in TRIAL.
REQ-010 TRIAL, index == 0: Guess takes the updated value, next state VERIFY.
REQ-011 VERIFY, Equal only: Result <= Guess, Found <= 1. Greater only or Less only: Result <= Guess, Found <= 0. Next state DONE in all cases.
REQ-012 In TRIAL or VERIFY, if the flags are not exactly one-hot (none set or more than one set), the block SHALL set Error <= 1, Found <= 0 and Result <= current Guess, and go to DONE.
REQ-013 DONE SHALL assert Done for exactly one cycle and then go to IDLE.
REQ-014 Busy SHALL be 1 in TRIAL and VERIFY and 0 in IDLE and DONE.
REQ-015 Start SHALL be ignored outside IDLE. Start asserted in the DONE cycle SHALL be ignored.
REQ-016 Result, Found, Error and Guess SHALL hold their values from DONE until the next accepted Start.
REQ-017 An accepted Start SHALL clear Found and Error in the same edge that loads Guess.
REQ-018 Latency, with Start sampled at edge 0:
- TRIAL occupies cycles 1..k, where k <= WIDTH
- VERIFY, if reached, occupies cycle WIDTH+1
- Done is high in cycle k+1 (early Equal) or WIDTH+2
- worst case for WIDTH=3: Done in cycle 5
REQ-019 Guess arithmetic SHALL be bit set/clear only, with no carries. Guess SHALL never exceed 2^WIDTH-1.

Reset
REQ-020 While rst=1, asynchronously: state = IDLE, Guess = 0, Result = 0, index = 0, Found = 0, Error = 0, Busy = 0, Done = 0.
REQ-021 Reset asserted mid-search SHALL abort the search without a Done pulse. After rst is released, the block SHALL wait in IDLE for a new Start.

Verification (WIDTH=3; bench models the comparator as A vs Guess)
REQ-022 A=4, Start pulsed at edge 0 -> Guess=4 in cycle 1; Done=1, Found=1, Result=4, Busy=0 in cycle 2.
REQ-023 A=0 -> Guess sequence 4,2,1 in TRIAL, then 0 in VERIFY; Done in cycle 5 with Result=0, Found=1, Error=0.
REQ-024 A=7 -> Guess sequence 4,6,7; Done in cycle 4 with Result=7, Found=1. A=5 -> Guess sequence 4,6,5; Done in cycle 4 with Result=5, Found=1.
REQ-025 Greater and Less both forced to 1 in cycle 1 -> Done in cycle 2 with Error=1, Found=0, Result=4. Next Start -> Error cleared.
REQ-026 Start re-pulsed in cycles 2 and 3 during the A=3 search -> ignored; the single search completes with Result=3.
REQ-027 rst asserted in cycle 2 of a search -> all outputs 0 immediately, no Done pulse. A new search with A=6 after rst release -> Result=6, Found=1.
